// File: rtl/alu_result_if.sv
// Write-back stage bus: ALU-side push channel and register-file drain channel.
// master = ALU/register-file side, slave = alu_result_stage.
interface alu_result_if #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_flags;
  logic [RD_W-1:0]  in_rd;
  logic             in_wb_en;
  logic             in_ld_status;
  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_data;
  logic [RD_W-1:0]  wb_rd;

  modport master (
    output in_valid, in_result, in_flags, in_rd, in_wb_en, in_ld_status, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_rd
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_rd, in_wb_en, in_ld_status, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: in-order write-back FIFO, status register {N,V,Z} and branch condition evaluation.
// Optional sticky overflow flag with ovf_sticky/ovf_clr ports when STICKY_OVF_EN is defined.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int RD_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_if.slave          io,
  output logic [2:0]           status,
  input  logic [2:0]           cond_sel,
  output logic                 cond_true,
`ifdef STICKY_OVF_EN
  output logic                 ovf_sticky,
  input  logic                 ovf_clr,
`endif
  input  logic                 flush
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_LE     = 3'b100;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [RD_W-1:0]  rd_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0] count,  count_next;

  logic [WIDTH-1:0] head_data;
  logic [RD_W-1:0]  head_rd;

  logic accept;
  logic push;
  logic pop;

  // Handshake terms; in_ready depends only on registered count so no in_valid->in_ready path exists.
  assign io.in_ready = (count != CNT_W'(DEPTH));
  assign io.wb_valid = (count != '0);
  assign io.wb_data  = head_data;
  assign io.wb_rd    = head_rd;

  assign accept = io.in_valid & io.in_ready;
  assign push   = accept & io.in_wb_en & ~flush;
  assign pop    = io.wb_valid & io.wb_ready & ~flush;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr + 1'b1;
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // NOTE: the storage array is not reset; an entry is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= io.in_result;
      rd_mem[wr_ptr]   <= io.in_rd;
    end
  end

  // Registered head copy: the next head is either a stored entry or the beat being pushed into
  // the slot that becomes the head. It holds its value whenever the FIFO goes empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_rd   <= '0;
    end else if (count_next != '0) begin
      if (push && (wr_ptr == rd_ptr_next)) begin
        head_data <= io.in_result;
        head_rd   <= io.in_rd;
      end else begin
        head_data <= data_mem[rd_ptr_next];
        head_rd   <= rd_mem[rd_ptr_next];
      end
    end
  end

  // Status loads from any accepted beat, independent of write-back and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= 3'b000;
    end else if (accept && io.in_ld_status) begin
      status <= io.in_flags;
    end
  end

`ifdef STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (accept && io.in_ld_status && io.in_flags[1]) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

  logic flag_n, flag_v, flag_z;
  assign flag_z = status[0];
  assign flag_v = status[1];
  assign flag_n = status[2];

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = flag_z;
      COND_NE:     cond_true = ~flag_z;
      COND_LT:     cond_true = flag_n ^ flag_v;
      COND_LE:     cond_true = (flag_n ^ flag_v) | flag_z;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus pushes expected write-backs, a monitor checks pops.
// Also exercises the STICKY_OVF_EN ports when that macro is defined.
module tb_alu_result_stage;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int RD_W  = 3;

  typedef struct packed {
    logic [RD_W-1:0]  rd;
    logic [WIDTH-1:0] data;
  } wb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] status;
  logic [2:0] cond_sel = 3'b000;
  logic       cond_true;
  logic       flush = 1'b0;
`ifdef STICKY_OVF_EN
  logic       ovf_sticky;
  logic       ovf_clr = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  wb_t exp_q[$];

  alu_result_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (bus.slave),
    .status    (status),
    .cond_sel  (cond_sel),
    .cond_true (cond_true),
`ifdef STICKY_OVF_EN
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr),
`endif
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every pop is compared against the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      wb_t e;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got rd=%0d data=0x%0h expected no write-back", bus.wb_rd, bus.wb_data);
      end else begin
        e = exp_q.pop_front();
        check("pop_rd", 32'(bus.wb_rd), 32'(e.rd));
        check("pop_data", 32'(bus.wb_data), 32'(e.data));
      end
    end
  end

  // One beat; waits (bounded) until accepted. Leaves inputs idle at posedge+#1.
  task automatic beat(input logic [WIDTH-1:0] data, input logic [RD_W-1:0] rd,
                      input logic [2:0] flags, input logic wb_en, input logic ld);
    bit ok = 0;
    bus.in_valid     = 1'b1;
    bus.in_result    = data;
    bus.in_rd        = rd;
    bus.in_flags     = flags;
    bus.in_wb_en     = wb_en;
    bus.in_ld_status = ld;
    for (int i = 0; i < 50; i++) begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) check("accept_timeout", 32'(0), 32'(1));
    else if (wb_en && !flush) exp_q.push_back('{rd: rd, data: data});
    bus.in_valid = 1'b0;
    bus.in_wb_en = 1'b0;
    bus.in_ld_status = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.wb_ready = 1'b1;
    while (bus.wb_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(bus.wb_valid), 32'(0));
    check("drain_queue", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic cond(input logic [2:0] sel, input logic exp_v, input string name);
    cond_sel = sel;
    #1;
    check(name, 32'(cond_true), 32'(exp_v));
  endtask

  initial begin
    bus.in_valid = 0; bus.in_result = '0; bus.in_rd = '0; bus.in_flags = '0;
    bus.in_wb_en = 0; bus.in_ld_status = 0; bus.wb_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_wb_valid", 32'(bus.wb_valid), 32'(0));
    check("rst_wb_data", 32'(bus.wb_data), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Reset mid-stream with two entries queued
    beat(16'h0101, 3'd3, 3'b101, 1'b1, 1'b1);
    beat(16'h0202, 3'd4, 3'b000, 1'b1, 1'b0);
    check("pre_rst_full", 32'(bus.in_ready), 32'(0));
    check("pre_rst_status", 32'(status), 32'(3'b101));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_wb_valid", 32'(bus.wb_valid), 32'(0));
    check("mid_rst_status", 32'(status), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    bus.wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_rst_no_stale", 32'(bus.wb_valid), 32'(0));
    bus.wb_ready = 1'b0;

    // Fill then drain in order
    beat(16'h0005, 3'd1, 3'b000, 1'b1, 1'b0);
    check("fill1_wb_valid", 32'(bus.wb_valid), 32'(1));
    check("fill1_head", 32'(bus.wb_data), 32'h0005);
    beat(16'hFFFF, 3'd2, 3'b000, 1'b1, 1'b0);
    check("fill_full", 32'(bus.in_ready), 32'(0));
    check("fill_head_hold", 32'(bus.wb_data), 32'h0005);
    drain();
    check("drain_in_ready", 32'(bus.in_ready), 32'(1));
    bus.wb_ready = 1'b0;

    // Simultaneous push and pop at count=1
    beat(16'h1234, 3'd5, 3'b000, 1'b1, 1'b0);
    bus.wb_ready = 1'b1;
    beat(16'h00AA, 3'd6, 3'b000, 1'b1, 1'b0);
    bus.wb_ready = 1'b0;
    check("pp_wb_valid", 32'(bus.wb_valid), 32'(1));
    check("pp_in_ready", 32'(bus.in_ready), 32'(1));
    check("pp_head_data", 32'(bus.wb_data), 32'h00AA);
    check("pp_head_rd", 32'(bus.wb_rd), 32'(6));

    // No write-back beat loads status only
    beat(16'hDEAD, 3'd7, 3'b001, 1'b0, 1'b1);
    check("nowb_head", 32'(bus.wb_data), 32'h00AA);
    check("nowb_in_ready", 32'(bus.in_ready), 32'(1));
    check("nowb_status", 32'(status), 32'(3'b001));
    cond(3'b001, 1'b1, "eq_z1");
    cond(3'b010, 1'b0, "ne_z1");
    drain();
    bus.wb_ready = 1'b0;

    // Conditions
    beat(16'h0, 3'd0, 3'b100, 1'b0, 1'b1);
    cond(3'b011, 1'b1, "lt_n");
    cond(3'b100, 1'b1, "le_n");
    cond(3'b000, 1'b1, "always");
    beat(16'h0, 3'd0, 3'b110, 1'b0, 1'b1);
    cond(3'b011, 1'b0, "lt_nv");
    cond(3'b100, 1'b0, "le_nv");
    beat(16'h0, 3'd0, 3'b011, 1'b0, 1'b1);
    cond(3'b100, 1'b1, "le_vz");
    cond(3'b011, 1'b1, "lt_v");
    cond(3'b101, 1'b0, "sel101");
    cond(3'b111, 1'b0, "sel111");
    beat(16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
    check("no_ld_hold", 32'(status), 32'(3'b011));

    // Flush with a queued entry and a same-cycle push that also loads status
    beat(16'h7777, 3'd2, 3'b000, 1'b1, 1'b0);
    flush = 1'b1;
    beat(16'h8888, 3'd3, 3'b100, 1'b1, 1'b1);
    flush = 1'b0;
    exp_q.delete();
    check("flush_wb_valid", 32'(bus.wb_valid), 32'(0));
    check("flush_in_ready", 32'(bus.in_ready), 32'(1));
    check("flush_status", 32'(status), 32'(3'b100));
    beat(16'h4242, 3'd1, 3'b000, 1'b1, 1'b0);
    check("post_flush_head", 32'(bus.wb_data), 32'h4242);
    drain();
    bus.wb_ready = 1'b0;

`ifdef STICKY_OVF_EN
    check("ovf_init", 32'(ovf_sticky), 32'(0));
    beat(16'h0, 3'd0, 3'b010, 1'b0, 1'b1);
    check("ovf_set", 32'(ovf_sticky), 32'(1));
    beat(16'h0, 3'd0, 3'b000, 1'b0, 1'b1);
    check("ovf_hold", 32'(ovf_sticky), 32'(1));
    ovf_clr = 1'b1;
    beat(16'h0, 3'd0, 3'b010, 1'b0, 1'b1);
    check("ovf_set_beats_clr", 32'(ovf_sticky), 32'(1));
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_sticky), 32'(0));
`endif

    repeat (2) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
